// File: rtl/fp_multiplier.sv
// fp_multiplier: IEEE-754 binary32 multiplier with one registered output stage
// ports: clk (rising-edge clock), reset (asynchronous, active-high; clears result),
//        a, b (binary32 operands, sampled every edge), result (registered a*b, 1-cycle latency)
// build macro FP_MUL_ROUND_EN: defined -> round-to-nearest-even, undefined -> round-toward-zero
module fp_multiplier (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);
`ifdef FP_MUL_ROUND_EN
    localparam logic rne = 1'b1;
`else
    localparam logic rne = 1'b0;
`endif
    logic s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, g, st, inc, carry;
    logic [47:0] p;
    logic [22:0] frac, fr;
    logic signed [9:0] e0, e1;
    logic [31:0] nxt;
    always_comb begin
        s = a[31] ^ b[31];
        a_zero = a[30:23] == 8'd0;
        b_zero = b[30:23] == 8'd0;
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        // 10-bit signed exponent so overflow and underflow never wrap before the range checks
        e0 = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127 + 10'(p[47]);
        frac = p[47] ? p[46:24] : p[45:23];
        g = p[47] ? p[23] : p[22];
        st = p[47] ? |p[22:0] : |p[21:0];
        inc = rne & g & (st | frac[0]);
        // an all-ones fraction that rounds up wraps to zero and bumps the exponent
        {carry, fr} = {1'b0, frac} + 24'(inc);
        e1 = e0 + 10'(carry);
        nxt = (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) ? 32'h7FC0_0000 :
              (a_inf | b_inf)   ? {s, 8'hFF, 23'h0} :
              (a_zero | b_zero) ? {s, 31'h0} :
              (e1 >= 10'sd255)  ? {s, 8'hFF, 23'h0} :
              (e1 <= 10'sd0)    ? {s, 31'h0} :
                                  {s, e1[7:0], fr};
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) result <= 32'h0;
        else result <= nxt;
endmodule

// File: tb/tb_fp_multiplier.sv
// tb_fp_multiplier: self-checking bench for fp_multiplier (real-arithmetic reference model + directed vectors)
module tb_fp_multiplier;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic [31:0] result;
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_r = 32'h0;
    bit valid = 1'b0;

    fp_multiplier dut (.clk(clk), .reset(reset), .a(a), .b(b), .result(result));

    always #5 clk = ~clk;

    function automatic real mag(input logic [31:0] x);
        real r = 1.0 + real'(x[22:0]) / 8388608.0;
        int e = int'(x[30:23]) - 127;
        while (e > 0) begin r = r * 2.0; e--; end
        while (e < 0) begin r = r / 2.0; e++; end
        return r;
    endfunction

    // product of two 24-bit significands is exact in a double, so rounding happens only here
    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y);
        logic s = x[31] ^ y[31];
        bit xz = x[30:23] == 0, yz = y[30:23] == 0;
        bit xi = x[30:23] == 255 && x[22:0] == 0, yi = y[30:23] == 255 && y[22:0] == 0;
        bit xn = x[30:23] == 255 && x[22:0] != 0, yn = y[30:23] == 255 && y[22:0] != 0;
        real m, t, r;
        int e = 0;
        longint f;
        if (xn || yn || (xi && yz) || (yi && xz)) return 32'h7FC0_0000;
        if (xi || yi) return {s, 8'hFF, 23'h0};
        if (xz || yz) return {s, 31'h0};
        m = mag(x) * mag(y);
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        t = (m - 1.0) * 8388608.0;
        f = longint'($floor(t));
        r = t - real'(f);
`ifdef FP_MUL_ROUND_EN
        if (r > 0.5 || (r == 0.5 && f[0])) f++;
`else
        r = 0.0;
`endif
        if (f == 64'd8388608) begin f = 0; e++; end
        e = e + 127;
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, 8'(e), f[22:0]};
    endfunction

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, act, want);
        end
    endtask

    always @(posedge clk or posedge reset)
        if (reset) begin
            exp_r <= 32'h0;
            valid <= 1'b0;
        end else begin
            exp_r <= model(a, b);
            valid <= 1'b1;
        end

    always @(negedge clk)
        if (!reset && valid) check("pipe", result, exp_r);

    task automatic apply(input string n, input logic [31:0] x, input logic [31:0] y, input logic [31:0] want);
        @(negedge clk);
        a = x;
        b = y;
        check({"model_", n}, model(x, y), want);
        @(posedge clk);
        #1 check(n, result, want);
    endtask

    logic [31:0] rnd_want;

    initial begin
`ifdef FP_MUL_ROUND_EN
        rnd_want = 32'h4010_0001;
`else
        rnd_want = 32'h4010_0000;
`endif
        #1 reset = 1'b1;
        #2 check("reset_async_initial", result, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        apply("half_sq", 32'h3F00_0000, 32'h3F00_0000, 32'h3E80_0000);
        apply("half_neg", 32'h3F00_0000, 32'hBEE0_0000, 32'hBE60_0000);
        apply("half_neg_swap", 32'hBEE0_0000, 32'h3F00_0000, 32'hBE60_0000);
        apply("neg_sq", 32'hBF40_0000, 32'hBF40_0000, 32'h3F10_0000);
        apply("round", 32'h3FC0_0001, 32'h3FC0_0000, rnd_want);
        apply("one_sq", 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        apply("overflow", 32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000);
        apply("max_keep", 32'h7F7F_FFFF, 32'h3F80_0000, 32'h7F7F_FFFF);
        apply("ftz", 32'h0080_0000, 32'h3F00_0000, 32'h0000_0000);
        apply("min_norm", 32'h0080_0000, 32'h3F80_0000, 32'h0080_0000);
        apply("inf_zero", 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
        apply("zero_neginf", 32'h0000_0000, 32'hFF80_0000, 32'h7FC0_0000);
        apply("nan_zero", 32'hFF80_0001, 32'h0000_0000, 32'h7FC0_0000);
        apply("neg_inf", 32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000);
        apply("neg_zero", 32'h8000_0000, 32'h3F80_0000, 32'h8000_0000);
        apply("daz", 32'h0000_0001, 32'h3F80_0000, 32'h0000_0000);
        apply("nonzero_before_reset", 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check("reset_async_mid", result, 32'h0);
        @(posedge clk);
        #1 check("reset_held", result, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        apply("after_reset", 32'h3F00_0000, 32'h3F00_0000, 32'h3E80_0000);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            a = {1'($urandom), 8'($urandom_range(60, 190)), 23'($urandom)};
            b = (i % 7 == 0) ? $urandom : {1'($urandom), 8'($urandom_range(60, 190)), 23'($urandom)};
        end
        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
